pipelined_csel_adder: RTL and testbench

PIPELINED_CSEL_ADDER -- requirements
Module: pipelined_csel_adder

---
 rtl/pipelined_csel_adder.sv | 83 ++++++++
 tb/tb_pipelined_csel_adder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_csel_adder.sv
// pipelined_csel_adder: NSEG-stage pipelined carry-select adder/subtractor with valid/ready handshake.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_a/in_b/in_cin/in_sub operand side;
// out_valid/out_ready/out_sum/out_cout/out_ovf result side.
// Macro PIPELINED_CSEL_ADDER_OVF_EN enables the registered signed-overflow flag; otherwise out_ovf is 0.
module pipelined_csel_adder #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int NSEG = WIDTH / SEG_W;
    logic [NSEG-1:0][WIDTH-1:0] a_q, b_q, s_q, s_d;
    logic [NSEG-1:0]            v_q, c_q, c_d;
    // Index 0 is the stage-0 input view; index k+1 is the register after stage k.
    logic [NSEG:0][WIDTH-1:0]   pa, pb, ps;
    logic [NSEG:0]              pv, pc;
    logic [SEG_W:0]             s0, s1, sel;
    logic                       adv;
    assign adv       = !(out_valid && !out_ready);
    assign in_ready  = adv;
    assign pa        = {a_q, in_a};
    assign pb        = {b_q, in_sub ? ~in_b : in_b};
    assign pc        = {c_q, in_sub | in_cin};
    assign ps        = {s_q, {WIDTH{1'b0}}};
    assign pv        = {v_q, in_valid};
    assign out_valid = v_q[NSEG-1];
    assign out_sum   = s_q[NSEG-1];
    assign out_cout  = c_q[NSEG-1];
    always_comb begin
        s_d = '0;
        c_d = '0;
        s0  = '0;
        s1  = '0;
        sel = '0;
        for (int k = 0; k < NSEG; k++) begin
            s0  = {1'b0, pa[k][k*SEG_W +: SEG_W]} + {1'b0, pb[k][k*SEG_W +: SEG_W]};
            s1  = s0 + (SEG_W+1)'(1);
            sel = pc[k] ? s1 : s0;
            s_d[k] = ps[k];
            s_d[k][k*SEG_W +: SEG_W] = sel[SEG_W-1:0];
            c_d[k] = sel[SEG_W];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
            c_q <= '0;
        end else if (adv) begin
            v_q <= pv[NSEG-1:0];
            a_q <= pa[NSEG-1:0];
            b_q <= pb[NSEG-1:0];
            s_q <= s_d;
            c_q <= c_d;
        end
    end
`ifdef PIPELINED_CSEL_ADDER_OVF_EN
    logic ovf_q, ovf_d;
    // sum^a^b at the MSB recovers the carry into it; xor with carry out gives overflow.
    assign ovf_d = s_d[NSEG-1][WIDTH-1] ^ pa[NSEG-1][WIDTH-1] ^ pb[NSEG-1][WIDTH-1] ^ c_d[NSEG-1];
    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else if (adv) ovf_q <= ovf_d;
    end
    assign out_ovf = ovf_q;
`else
    assign out_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_csel_adder.sv
// tb_pipelined_csel_adder: directed and randomized checks of the pipelined carry-select adder.
module tb_pipelined_csel_adder;
`ifdef PIPELINED_CSEL_ADDER_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        in_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    pipelined_csel_adder #(.WIDTH(32), .SEG_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [31:0] bb;
        logic [32:0] f;
        logic        ov;
        bb = sub ? ~b : b;
        f  = {1'b0, a} + {1'b0, bb} + {32'd0, sub ? 1'b1 : cin};
        ov = OVF_EN && (a[31] == bb[31]) && (f[31] != a[31]);
        return {ov, f};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; in_a = 32'h1234_5678; in_b = 32'h1111_1111; out_ready = 1'b1;
        tick; tick;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_sum !== 32'h0) $display("FAIL reset_sum got %h want 0", out_sum); else pass_cnt++;
        total_cnt++; if (out_cout !== 1'b0) $display("FAIL reset_cout got %b want 0", out_cout); else pass_cnt++;
        total_cnt++; if (out_ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", out_ovf); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                tick;
                if (out_valid) seen++;
            end
            total_cnt++; if (seen != 0) $display("FAIL reset_no_leak got %0d outputs want 0", seen); else pass_cnt++;
        end
    endtask

    task automatic test_single(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input logic sub,
                               input logic [31:0] es, input logic ec, input logic eo);
        int n;
        out_ready = 1'b1; in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        tick;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 12) begin
            tick;
            n++;
        end
        total_cnt++; if (n != 4) $display("FAIL %s_latency got %0d want 4", name, n); else pass_cnt++;
        total_cnt++; if (out_sum !== es) $display("FAIL %s_sum got %h want %h", name, out_sum, es); else pass_cnt++;
        total_cnt++; if (out_cout !== ec) $display("FAIL %s_cout got %b want %b", name, out_cout, ec); else pass_cnt++;
        total_cnt++; if (out_ovf !== eo) $display("FAIL %s_ovf got %b want %b", name, out_ovf, eo); else pass_cnt++;
        tick;
    endtask

    task automatic test_back_to_back;
        int  ni = 0, no = 0, stall = 0, extra = 0;
        bit  seen = 1'b0;
        for (int cyc = 0; cyc < 60 && no < 8; cyc++) begin
            if (out_valid && !seen) begin
                seen = 1'b1;
                stall = 3;
            end
            out_ready = (stall == 0);
            in_valid = (ni < 8); in_a = 32'(ni); in_b = 32'h1000_0000 * 32'(ni); in_cin = 1'b0; in_sub = 1'b0;
            #1;
            if (out_valid && !out_ready) begin
                total_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_in_ready got %b want 0", in_ready); else pass_cnt++;
                total_cnt++; if (out_sum !== 32'h1000_0001 * 32'(no)) $display("FAIL b2b_hold got %h want %h", out_sum, 32'h1000_0001 * 32'(no)); else pass_cnt++;
            end
            if (out_valid && out_ready) begin
                total_cnt++;
                if (out_sum !== 32'h1000_0001 * 32'(no) || out_cout !== 1'b0 || out_ovf !== 1'b0)
                    $display("FAIL b2b_result[%0d] got %h/%b/%b want %h/0/0", no, out_sum, out_cout, out_ovf, 32'h1000_0001 * 32'(no));
                else pass_cnt++;
                no++;
            end
            if (in_valid && in_ready) ni++;
            if (stall > 0) stall--;
            tick;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) extra++;
            tick;
        end
        total_cnt++; if (no != 8) $display("FAIL b2b_count got %0d want 8", no); else pass_cnt++;
        total_cnt++; if (extra != 0) $display("FAIL b2b_dup got %0d extra want 0", extra); else pass_cnt++;
    endtask

    task automatic test_reset_inflight;
        int seen = 0;
        out_ready = 1'b1; in_cin = 1'b0; in_sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 32'hA000_0000 + 32'(i); in_b = 32'h0000_0F00;
            tick;
        end
        rst = 1'b1; in_a = 32'hDEAD_BEEF;
        tick;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rstf_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_sum !== 32'h0 || out_cout !== 1'b0 || out_ovf !== 1'b0)
            $display("FAIL rstf_outputs got %h/%b/%b want 0/0/0", out_sum, out_cout, out_ovf); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rstf_in_ready got %b want 1", in_ready); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (out_valid) seen++;
        end
        total_cnt++; if (seen != 0) $display("FAIL rstf_ghost got %0d outputs want 0", seen); else pass_cnt++;
    endtask

    function automatic logic [31:0] pick_operand();
        int r;
        r = $urandom_range(0, 7);
        return r == 0 ? 32'h0 : r == 1 ? 32'hFFFF_FFFF : r == 2 ? 32'h7FFF_FFFF : r == 3 ? 32'h8000_0000 : $urandom;
    endfunction

    task automatic test_random;
        logic [33:0] q[$];
        logic [33:0] e;
        int sent = 0, bad = 0, cyc = 0;
        while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
            in_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
            in_a = pick_operand(); in_b = pick_operand();
            in_cin = 1'($urandom_range(0, 1)); in_sub = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                total_cnt++;
                if (q.size() == 0) begin
                    $display("FAIL rand_spurious got %h with empty queue", out_sum);
                end else begin
                    e = q.pop_front();
                    if ({out_ovf, out_cout, out_sum} !== e) begin
                        if (bad < 10) $display("FAIL rand_result got %b/%b/%h want %b/%b/%h", out_ovf, out_cout, out_sum, e[33], e[32], e[31:0]);
                        bad++;
                    end else pass_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_a, in_b, in_cin, in_sub));
                sent++;
            end
            tick;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total_cnt++; if (q.size() != 0 || sent != 10000) $display("FAIL rand_drain got sent=%0d pending=%0d want 10000/0", sent, q.size()); else pass_cnt++;
    endtask

    initial begin
        tick;
        test_reset;
        test_single("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        test_single("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        test_single("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, OVF_EN);
        test_single("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, OVF_EN);
        test_single("add_cin", 32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        test_single("add_chain", 32'h1234_5678, 32'h0FED_CBA8, 1'b0, 1'b0, 32'h2222_2220, 1'b0, 1'b0);
        test_single("sub_zero", 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        test_back_to_back;
        test_reset_inflight;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
